// File: rtl/hms_alarm_if.sv
// Control pulses from the switch controller and display/buzzer outputs of the
// alarm clock core, bundled so the core and its driver share one port.
interface hms_alarm_if;
  logic [1:0] i_mode;
  logic [1:0] i_pos;
  logic       i_inc;
  logic       i_dec;
  logic       i_alarm_en;
  logic       i_snooze;
  logic       i_stop;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;
  logic       o_ringing;
  logic       o_snoozing;

  modport master (
    output i_mode, i_pos, i_inc, i_dec, i_alarm_en, i_snooze, i_stop,
    input  o_sec, o_min, o_hour, o_tick, o_ringing, o_snoozing
  );

  modport slave (
    input  i_mode, i_pos, i_inc, i_dec, i_alarm_en, i_snooze, i_stop,
    output o_sec, o_min, o_hour, o_tick, o_ringing, o_snoozing
  );
endinterface

// File: rtl/hms_alarm_core.sv
// hh:mm:ss timekeeper driven by a one-cycle 1 Hz enable, with an editable hh:mm
// alarm and an IDLE/RING/SNOOZE controller that gates the buzzer.
module hms_alarm_core #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOUR_MAX   = 23,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60
) (
  input  logic        clk,
  input  logic        rst,
  hms_alarm_if.slave  bus
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int SMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int CW   = $clog2(SMAX + 1);

  localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [4:0]    HMAX        = 5'(HOUR_MAX);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  logic [PW-1:0] pre_reg;
  logic          tick_reg;
  logic [5:0]    sec_reg, min_reg;
  logic [4:0]    hour_reg;
  logic [5:0]    alarm_min_reg;
  logic [4:0]    alarm_hour_reg;
  state_t        state_reg;
  logic [CW-1:0] sec_cnt_reg;
  logic          ringing_reg, snoozing_reg;

  logic [5:0]    run_sec_next, run_min_next;
  logic [4:0]    run_hour_next;
  logic          set_time, set_alarm, advance, edit, match;

  function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] wrap_hour(input logic [4:0] v, input logic up);
    if (up) return (v == HMAX) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? HMAX : v - 5'd1;
  endfunction

  assign set_time  = (bus.i_mode == 2'b01);
  assign set_alarm = (bus.i_mode == 2'b10);
  assign advance   = tick_reg && !set_time;
  // Simultaneous inc and dec cancel out.
  assign edit      = bus.i_inc ^ bus.i_dec;

  always_comb begin
    run_sec_next  = sec_reg + 6'd1;
    run_min_next  = min_reg;
    run_hour_next = hour_reg;
    if (sec_reg == 6'd59) begin
      run_sec_next = 6'd0;
      if (min_reg == 6'd59) begin
        run_min_next  = 6'd0;
        run_hour_next = (hour_reg == HMAX) ? 5'd0 : hour_reg + 5'd1;
      end else begin
        run_min_next = min_reg + 6'd1;
      end
    end
  end

  // Only a running tick can fire the alarm; edits into equality never do.
  assign match = advance && bus.i_alarm_en && (run_sec_next == 6'd0) &&
                 (run_min_next == alarm_min_reg) && (run_hour_next == alarm_hour_reg);

  always_ff @(posedge clk) begin
    if (rst || set_time) begin
      pre_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (pre_reg == PRE_LAST);
      pre_reg  <= (pre_reg == PRE_LAST) ? '0 : pre_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_reg  <= '0;
      min_reg  <= '0;
      hour_reg <= '0;
    end else if (advance) begin
      sec_reg  <= run_sec_next;
      min_reg  <= run_min_next;
      hour_reg <= run_hour_next;
    end else if (set_time && edit) begin
      case (bus.i_pos)
        2'd0:    sec_reg  <= wrap60(sec_reg, bus.i_inc);
        2'd1:    min_reg  <= wrap60(min_reg, bus.i_inc);
        2'd2:    hour_reg <= wrap_hour(hour_reg, bus.i_inc);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_min_reg  <= '0;
      alarm_hour_reg <= '0;
    end else if (set_alarm && edit) begin
      case (bus.i_pos)
        2'd1:    alarm_min_reg  <= wrap60(alarm_min_reg, bus.i_inc);
        2'd2:    alarm_hour_reg <= wrap_hour(alarm_hour_reg, bus.i_inc);
        default: ;
      endcase
    end
  end

  // The per-second counter restarts on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      sec_cnt_reg  <= '0;
      ringing_reg  <= 1'b0;
      snoozing_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (match) begin
            state_reg   <= ST_RING;
            sec_cnt_reg <= '0;
            ringing_reg <= 1'b1;
          end
        end
        ST_RING: begin
          if (bus.i_stop || !bus.i_alarm_en || (tick_reg && sec_cnt_reg == RING_LAST)) begin
            state_reg   <= ST_IDLE;
            sec_cnt_reg <= '0;
            ringing_reg <= 1'b0;
          end else if (bus.i_snooze) begin
            state_reg    <= ST_SNOOZE;
            sec_cnt_reg  <= '0;
            ringing_reg  <= 1'b0;
            snoozing_reg <= 1'b1;
          end else if (tick_reg) begin
            sec_cnt_reg <= sec_cnt_reg + CW'(1);
          end
        end
        ST_SNOOZE: begin
          if (bus.i_stop || !bus.i_alarm_en) begin
            state_reg    <= ST_IDLE;
            sec_cnt_reg  <= '0;
            snoozing_reg <= 1'b0;
          end else if (tick_reg && sec_cnt_reg == SNOOZE_LAST) begin
            state_reg    <= ST_RING;
            sec_cnt_reg  <= '0;
            snoozing_reg <= 1'b0;
            ringing_reg  <= 1'b1;
          end else if (tick_reg) begin
            sec_cnt_reg <= sec_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          sec_cnt_reg  <= '0;
          ringing_reg  <= 1'b0;
          snoozing_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sec      = set_alarm ? 6'd0 : sec_reg;
  assign bus.o_min      = set_alarm ? alarm_min_reg : min_reg;
  assign bus.o_hour     = set_alarm ? alarm_hour_reg : hour_reg;
  assign bus.o_tick     = tick_reg;
  assign bus.o_ringing  = ringing_reg;
  assign bus.o_snoozing = snoozing_reg;

endmodule

// File: tb/tb_hms_alarm_core.sv
// Alarm clock bench: seconds-of-day reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hms_alarm_core;
  localparam int TD  = 4;
  localparam int HM  = 23;
  localparam int SN  = 5;
  localparam int RS  = 3;
  localparam int NH  = HM + 1;
  localparam int DAY = NH * 3600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hms_alarm_if bus_if();

  hms_alarm_core #(
    .TICK_DIV(TD), .HOUR_MAX(HM), .SNOOZE_SEC(SN), .RING_SEC(RS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk    = 1'b0;

  // Model: time as seconds of day, alarm as minute of day, FSM as 0 idle/1 ring/2 snooze.
  int m_t = 0, m_am = 0, m_phase = 0, m_st = 0, m_cnt = 0;
  bit m_tick = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  d, s, mi, h;
    bit  adv, hit, tk;
    int  md;
    md = int'(bus_if.i_mode);
    if (rst) begin
      m_t = 0; m_am = 0; m_phase = 0; m_tick = 0; m_st = 0; m_cnt = 0;
      return;
    end
    tk  = m_tick;
    adv = tk && (md != 1);
    hit = adv && bus_if.i_alarm_en && (((m_t + 1) % DAY) == m_am * 60);
    d   = int'(bus_if.i_inc) - int'(bus_if.i_dec);
    case (m_st)
      0: if (hit) begin m_st = 1; m_cnt = 0; end
      1: begin
        if (tk) m_cnt++;
        if (bus_if.i_stop || !bus_if.i_alarm_en || (tk && m_cnt >= RS)) begin
          m_st = 0; m_cnt = 0;
        end else if (bus_if.i_snooze) begin
          m_st = 2; m_cnt = 0;
        end
      end
      default: begin
        if (tk) m_cnt++;
        if (bus_if.i_stop || !bus_if.i_alarm_en) begin
          m_st = 0; m_cnt = 0;
        end else if (m_cnt >= SN) begin
          m_st = 1; m_cnt = 0;
        end
      end
    endcase
    if (adv) begin
      m_t = (m_t + 1) % DAY;
    end else if (md == 1 && d != 0) begin
      s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
      case (int'(bus_if.i_pos))
        0: s  = (s + d + 60) % 60;
        1: mi = (mi + d + 60) % 60;
        2: h  = (h + d + NH) % NH;
        default: ;
      endcase
      m_t = h * 3600 + mi * 60 + s;
    end
    if (md == 2 && d != 0) begin
      mi = m_am % 60; h = m_am / 60;
      if (bus_if.i_pos == 2'd1) mi = (mi + d + 60) % 60;
      if (bus_if.i_pos == 2'd2) h  = (h + d + NH) % NH;
      m_am = h * 60 + mi;
    end
    if (md == 1) begin
      m_phase = 0; m_tick = 0;
    end else begin
      m_tick  = (m_phase == TD - 1);
      m_phase = (m_phase + 1) % TD;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk) begin
      if (bus_if.i_mode == 2'd2) begin
        check("sec", int'(bus_if.o_sec), 0);
        check("min", int'(bus_if.o_min), m_am % 60);
        check("hour", int'(bus_if.o_hour), m_am / 60);
      end else begin
        check("sec", int'(bus_if.o_sec), m_t % 60);
        check("min", int'(bus_if.o_min), (m_t / 60) % 60);
        check("hour", int'(bus_if.o_hour), m_t / 3600);
      end
      check("tick", int'(bus_if.o_tick), int'(m_tick));
      check("ringing", int'(bus_if.o_ringing), int'(m_st == 1));
      check("snoozing", int'(bus_if.o_snoozing), int'(m_st == 2));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_field(input int md, input int ps, input int target);
    int cur, modv, n;
    bus_if.i_mode = 2'(md);
    bus_if.i_pos  = 2'(ps);
    modv = (ps == 2) ? NH : 60;
    if (md == 1) cur = (ps == 0) ? m_t % 60 : (ps == 1) ? (m_t / 60) % 60 : m_t / 3600;
    else         cur = (ps == 1) ? m_am % 60 : m_am / 60;
    n = (target - cur + modv) % modv;
    if (n <= modv / 2) begin
      bus_if.i_inc = 1'b1; cyc(n); bus_if.i_inc = 1'b0;
    end else begin
      bus_if.i_dec = 1'b1; cyc(modv - n); bus_if.i_dec = 1'b0;
    end
  endtask

  task automatic wait_tick(input string name, output int ncyc);
    ncyc = 0;
    do begin
      cyc(1);
      ncyc++;
    end while (!bus_if.o_tick && ncyc < 20);
    check(name, int'(bus_if.o_tick), 1);
  endtask

  // Preset 07:29:59 against the 07:30 alarm and run until it rings.
  task automatic arm_and_ring(input string name, output bit prev_tick);
    set_field(1, 2, 7);
    set_field(1, 1, 29);
    set_field(1, 0, 59);
    bus_if.i_alarm_en = 1'b1;
    bus_if.i_mode = 2'd0;
    bus_if.i_pos  = 2'd3;
    prev_tick = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_tick = bus_if.o_tick;
      cyc(1);
      if (bus_if.o_ringing) break;
    end
    check(name, int'(bus_if.o_ringing), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nc, nt;
    bit  pt;
    bus_if.i_mode = 2'd0; bus_if.i_pos = 2'd3;
    bus_if.i_inc = 1'b0; bus_if.i_dec = 1'b0;
    bus_if.i_alarm_en = 1'b0; bus_if.i_snooze = 1'b0; bus_if.i_stop = 1'b0;
    cyc(1);
    chk = 1'b1;
    cyc(1);
    check("rst_sec", int'(bus_if.o_sec), 0);
    check("rst_hour", int'(bus_if.o_hour), 0);
    check("rst_ring", int'(bus_if.o_ringing), 0);
    rst = 1'b0;

    // Day wrap and tick spacing.
    set_field(1, 2, 23);
    set_field(1, 1, 59);
    set_field(1, 0, 58);
    check("preset_hour", int'(bus_if.o_hour), 23);
    check("preset_sec", int'(bus_if.o_sec), 58);
    bus_if.i_mode = 2'd0;
    wait_tick("wrap_tick1", nc);
    cyc(1);
    check("wrap_s59", int'(bus_if.o_sec), 59);
    check("wrap_m59", int'(bus_if.o_min), 59);
    nc = 1;
    while (!bus_if.o_tick && nc < 20) begin cyc(1); nc++; end
    check("tick_spacing", nc, 4);
    cyc(1);
    check("wrap_sec0", int'(bus_if.o_sec), 0);
    check("wrap_min0", int'(bus_if.o_min), 0);
    check("wrap_hour0", int'(bus_if.o_hour), 0);

    // Field editing without carry.
    set_field(1, 2, 3);
    set_field(1, 1, 12);
    set_field(1, 0, 59);
    bus_if.i_inc = 1'b1; cyc(1); bus_if.i_inc = 1'b0;
    check("set_inc_sec", int'(bus_if.o_sec), 0);
    check("set_inc_min", int'(bus_if.o_min), 12);
    check("set_inc_hour", int'(bus_if.o_hour), 3);
    bus_if.i_dec = 1'b1; cyc(1); bus_if.i_dec = 1'b0;
    check("set_dec_sec", int'(bus_if.o_sec), 59);
    bus_if.i_inc = 1'b1; bus_if.i_dec = 1'b1; cyc(1);
    bus_if.i_inc = 1'b0; bus_if.i_dec = 1'b0;
    check("set_both_sec", int'(bus_if.o_sec), 59);
    check("set_both_min", int'(bus_if.o_min), 12);

    // Alarm at 07:30.
    set_field(2, 2, 7);
    set_field(2, 1, 30);
    check("alarm_disp_sec", int'(bus_if.o_sec), 0);
    check("alarm_disp_min", int'(bus_if.o_min), 30);
    arm_and_ring("alarm_ring", pt);
    check("alarm_hour", int'(bus_if.o_hour), 7);
    check("alarm_min", int'(bus_if.o_min), 30);
    check("alarm_sec", int'(bus_if.o_sec), 0);
    check("ring_after_tick", int'(pt), 1);

    // Snooze then re-ring after SN ticks.
    bus_if.i_snooze = 1'b1; cyc(1); bus_if.i_snooze = 1'b0;
    check("snooze_on", int'(bus_if.o_snoozing), 1);
    check("snooze_ring_off", int'(bus_if.o_ringing), 0);
    nt = int'(bus_if.o_tick);
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (bus_if.o_ringing) break;
      if (bus_if.o_tick) nt++;
    end
    check("rering", int'(bus_if.o_ringing), 1);
    check("snooze_ticks", nt, SN);

    // Ring times out after RS ticks.
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!bus_if.o_ringing) break;
      if (bus_if.o_tick) nt++;
    end
    check("timeout_off", int'(bus_if.o_ringing), 0);
    check("timeout_ticks", nt, RS);

    // Stop beats snooze.
    arm_and_ring("ring2", pt);
    bus_if.i_stop = 1'b1; bus_if.i_snooze = 1'b1; cyc(1);
    bus_if.i_stop = 1'b0; bus_if.i_snooze = 1'b0;
    check("stop_ring", int'(bus_if.o_ringing), 0);
    check("stop_snooze", int'(bus_if.o_snoozing), 0);
    cyc(2);
    check("stop_stays", int'(bus_if.o_snoozing), 0);

    // Reset during ring.
    arm_and_ring("ring3", pt);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("rr_ring", int'(bus_if.o_ringing), 0);
    check("rr_snooze", int'(bus_if.o_snoozing), 0);
    check("rr_sec", int'(bus_if.o_sec), 0);
    check("rr_min", int'(bus_if.o_min), 0);
    check("rr_hour", int'(bus_if.o_hour), 0);
    check("rr_tick", int'(bus_if.o_tick), 0);
    bus_if.i_mode = 2'd2;
    #1;
    check("rr_alarm_min", int'(bus_if.o_min), 0);
    check("rr_alarm_hour", int'(bus_if.o_hour), 0);
    cyc(1);

    // Randomized traffic with the alarm set one minute ahead.
    for (int k = 0; k < 8; k++) begin
      int tm;
      tm = ((m_t / 60) + 1) % (NH * 60);
      bus_if.i_alarm_en = 1'b1;
      set_field(2, 2, tm / 60);
      set_field(2, 1, tm % 60);
      for (int c = 0; c < 400; c++) begin
        if (c % 16 == 0) begin
          bus_if.i_mode = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
          bus_if.i_pos  = 2'($urandom_range(0, 3));
        end
        bus_if.i_inc    = ($urandom_range(0, 7) == 0);
        bus_if.i_dec    = ($urandom_range(0, 7) == 0);
        bus_if.i_snooze = ($urandom_range(0, 19) == 0);
        bus_if.i_stop   = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 99) == 0) bus_if.i_alarm_en = ~bus_if.i_alarm_en;
        rst = ($urandom_range(0, 999) == 0);
        cyc(1);
      end
      rst = 1'b0;
      bus_if.i_inc = 1'b0; bus_if.i_dec = 1'b0;
      bus_if.i_snooze = 1'b0; bus_if.i_stop = 1'b0;
    end

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
